nonres_div_seq_ctrl: RTL and testbench

//  Sequential controller for unsigned non-restoring division: one add/sub step per clock,

---
 rtl/nonres_div_seq_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_nonres_div_seq_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/nonres_div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// nonres_div_seq_ctrl
// Sequential unsigned non-restoring divider controller. One add/sub step per
// clock on a single (VW+2)-bit datapath. Operands arrive on a valid/ready
// input handshake and results leave on a valid/ready output handshake.
//
// Build option: define NONRES_REM_CORRECT_EN to add a one-cycle CORR state
// that turns the raw remainder (range [-D, D-1]) into the true non-negative
// remainder. Without it the consumer adds D when remainder is negative.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   operand handshake (ready only in IDLE)
//   dividend, divisor     unsigned operands (DW / VW bits)
//   abort                 synchronous flush to IDLE, highest priority
//   out_valid / out_ready result handshake (valid held until taken)
//   quotient              DW-bit unsigned quotient
//   remainder             VW+1-bit two's complement remainder
//   div_by_zero           result was produced with divisor == 0
//   busy                  controller is not IDLE
// -----------------------------------------------------------------------------
module nonres_div_seq_ctrl #(
  parameter int DW = 4,
  parameter int VW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  input  logic          abort,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW:0]   remainder,
  output logic          div_by_zero,
  output logic          busy
);

  localparam int PW = VW + 2;                        // partial remainder width
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;     // step counter width

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_CORR = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  p_q, p_d;
  logic [DW-1:0]  q_q, q_d;
  logic [DW-1:0]  dvd_q, dvd_d;
  logic [VW-1:0]  dvs_q, dvs_d;
  logic [DW-1:0]  quo_q, quo_d;
  logic [VW:0]    rem_q, rem_d;
  logic           dbz_q, dbz_d;
  logic           in_ready_q, out_valid_q, busy_q;

  logic [PW-1:0]  d_ext_s;
  logic [PW-1:0]  p_shift_s;
  logic [PW-1:0]  p_step_s;

  // Datapath: shift in the next dividend bit, then subtract D while P is
  // non-negative, add D while negative. 2P+bit stays within VW+2 signed bits
  // because P never leaves [-D, D-1].
  always_comb begin
    d_ext_s   = {2'b00, dvs_q};
    p_shift_s = {p_q[PW-2:0], dvd_q[cnt_q]};
    if (p_q[PW-1]) begin
      p_step_s = p_shift_s + d_ext_s;
    end else begin
      p_step_s = p_shift_s - d_ext_s;
    end
  end

  // Next-state and register-next logic; abort overrides every state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            dvd_d = dividend;
            dvs_d = divisor;
            p_d   = '0;
            q_d   = '0;
            cnt_d = CW'(DW - 1);
            if (divisor == '0) begin
              state_d = S_DONE;
              quo_d   = '1;
              rem_d   = '0;
              dbz_d   = 1'b1;
            end else begin
              state_d = S_ITER;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ITER: begin
          p_d        = p_step_s;
          q_d[cnt_q] = ~p_step_s[PW-1];
          if (cnt_q == '0) begin
`ifdef NONRES_REM_CORRECT_EN
            state_d = S_CORR;
`else
            state_d = S_DONE;
            quo_d   = q_d;
            rem_d   = p_step_s[VW:0];
            dbz_d   = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
`ifdef NONRES_REM_CORRECT_EN
        S_CORR: begin
          // Always one cycle so latency does not depend on the operands.
          if (p_q[PW-1]) begin
            p_d = p_q + d_ext_s;
          end else begin
            p_d = p_q;
          end
          state_d = S_DONE;
          quo_d   = q_q;
          rem_d   = p_d[VW:0];
          dbz_d   = 1'b0;
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      p_q         <= '0;
      q_q         <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      q_q         <= q_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_DONE);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_nonres_div_seq_ctrl.sv
module tb_nonres_div_seq_ctrl;

  localparam int DW = 4;
  localparam int VW = 2;
`ifdef NONRES_REM_CORRECT_EN
  localparam int CORR_STEPS = 1;
`else
  localparam int CORR_STEPS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          abort = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] quotient;
  logic [VW:0]   remainder;
  logic          div_by_zero;
  logic          busy;

  int n_vec = 0;
  int n_mis = 0;

  // reference model: phase flags, remaining cycles, published results
  bit            m_idle = 1'b1;
  bit            m_done = 1'b0;
  int            m_left = 0;
  logic [DW-1:0] m_q = '0, p_q = '0;
  logic [VW:0]   m_r = '0, p_r = '0;
  logic          m_dz = 1'b0, p_dz = 1'b0;

  nonres_div_seq_ctrl #(.DW(DW), .VW(VW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Results from plain integer division; the raw remainder is the value
  // congruent to a mod b in [-b, b-1], negative exactly when the quotient is even.
  task automatic compute(input int a, input int b);
    int q, r;
    if (b == 0) begin
      p_q = '1; p_r = '0; p_dz = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      if (CORR_STEPS == 0 && (q % 2) == 0) r = r - b;
      p_q = q[DW-1:0];
      p_r = r[VW:0];
      p_dz = 1'b0;
    end
  endtask

  task automatic model_update();
    if (!rst_n) begin
      m_idle = 1'b1; m_done = 1'b0; m_left = 0;
      m_q = '0; m_r = '0; m_dz = 1'b0;
    end else if (abort) begin
      m_idle = 1'b1; m_done = 1'b0; m_left = 0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_idle = 1'b0;
        compute(int'(dividend), int'(divisor));
        if (divisor == '0) begin
          m_done = 1'b1;
          m_q = p_q; m_r = p_r; m_dz = p_dz;
        end else begin
          m_left = DW + CORR_STEPS;
        end
      end
    end else if (!m_done) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_q = p_q; m_r = p_r; m_dz = p_dz;
      end
    end else if (out_ready) begin
      m_idle = 1'b1; m_done = 1'b0;
    end
  endtask

  task automatic compare_all();
    chk("in_ready",    in_ready,    m_idle);
    chk("busy",        busy,        !m_idle);
    chk("out_valid",   out_valid,   m_done);
    chk("quotient",    quotient,    m_q);
    chk("remainder",   remainder,   m_r);
    chk("div_by_zero", div_by_zero, m_dz);
  endtask

  // one clock: model follows the edge, DUT checked on the falling edge
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_op(input string nm, input int a, input int b, input int eq,
                        input int er, input int edz, input int elat, input int hold);
    int n;
    in_valid = 1'b1; dividend = a[DW-1:0]; divisor = b[VW-1:0]; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n = 1;
    while (out_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({nm, "_latency"}, n, elat);
    chk({nm, "_quotient"}, quotient, eq);
    chk({nm, "_remainder"}, remainder, er);
    chk({nm, "_dbz"}, div_by_zero, edz);
    chk({nm, "_in_ready_done"}, in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({nm, "_hold_valid"}, out_valid, 1);
      chk({nm, "_hold_quotient"}, quotient, eq);
      chk({nm, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({nm, "_drop_valid"}, out_valid, 0);
    chk({nm, "_back_idle"}, in_ready, 1);
  endtask

  initial begin
    logic [VW:0] r13;
    int lat;
`ifdef NONRES_REM_CORRECT_EN
    r13 = 3'b001;
`else
    r13 = 3'b110;
`endif
    lat = DW + 1 + CORR_STEPS;

    step();
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    step();

    run_op("d13_3", 13, 3, 4, int'(r13), 0, lat, 0);
    run_op("d15_1", 15, 1, 15, 0, 0, lat, 0);
    run_op("d7_2", 7, 2, 3, 1, 0, lat, 0);
    run_op("d9_0", 9, 0, 15, 0, 1, 1, 0);
    run_op("hold13_3", 13, 3, 4, int'(r13), 0, lat, 10);

    // abort in the second ITER cycle
    in_valid = 1'b1; dividend = 4'd11; divisor = 2'd2;
    step();
    in_valid = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_keep_q", quotient, 4);
    for (int i = 0; i < DW + 3; i++) begin
      step();
      chk("abort_no_valid", out_valid, 0);
    end

    // async reset mid-ITER
    in_valid = 1'b1; dividend = 4'd14; divisor = 2'd3;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_quotient", quotient, 0);
    chk("arst_remainder", remainder, 0);
    chk("arst_dbz", div_by_zero, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < DW + 3; i++) begin
      step();
      chk("arst_no_valid", out_valid, 0);
    end

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      dividend  = DW'($urandom_range(0, (1 << DW) - 1));
      divisor   = VW'($urandom_range(0, (1 << VW) - 1));
      out_ready = ($urandom_range(0, 2) != 0);
      abort     = ($urandom_range(0, 24) == 0);
      step();
    end
    abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
